count_seq: RTL and testbench
============================

COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 Parameter WIDTH, default 4, count/target width.
REQ-002 Parameter DWELL_W, default 4, dwell-length width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel the sweep in progress; count freezes.
REQ-007 target  input  WIDTH  sweep endpoint; latched on accepted start.
REQ-008 dwell  input  DWELL_W  hold length at target; latched on accepted start.
REQ-009 count  output  WIDTH  current counter value.
REQ-010 busy  output  1  high in SEEK, DWELL, RETURN.
REQ-011 done  output  1  one-cycle pulse on sweep completion.
REQ-012 dir  output  1  current step direction: 1 = down, 0 = up.

Function
REQ-013 Block SHALL sequence one internal up/down counter through the sweep 0/current -> target -> hold -> 0, driving the counter's en and dn itself.
REQ-014 States SHALL be IDLE, SEEK, DWELL, RETURN, DONE.
REQ-015 IDLE: en=0; start=1 and abort=0 at an edge -> SEEK; target and dwell latched on that edge; dir latched = (count > target).
REQ-016 SEEK: while count != latched target, en=1, dn=dir, and count steps by 1 per edge; the edge on which count == target -> DWELL, dwell counter loaded with latched dwell.
REQ-017 Target equal to count at start: SEEK lasts exactly 1 cycle with en=0.
REQ-018 DWELL: en=0; lasts latched dwell + 1 cycles (dwell=0 -> 1 cycle), then -> RETURN.
REQ-019 RETURN: dir=1; en=1 while count != 0, count decrements per edge; edge with count == 0 -> DONE.
REQ-020 DONE: en=0, done=1, busy=0 for exactly one cycle, then -> IDLE.
REQ-021 Latency example: count=0, target=3, dwell=1, start at edge k: count=1,2,3 after edges k+1..k+3; DWELL after k+4; RETURN after k+6; count=0 after edge k+9; DONE after k+10; done high for one cycle.
REQ-022 start while busy or in DONE SHALL be ignored, with no relatching.
REQ-023 abort in SEEK, DWELL or RETURN SHALL force IDLE at the next edge; count holds its value; done stays 0.
REQ-024 abort and start both high in IDLE SHALL leave the state at IDLE.
REQ-025 Count SHALL never wrap; direction selection guarantees monotonic steps toward the endpoint.
REQ-026 en and dn SHALL be combinational from state, count and latched registers; all outputs except count are glitch-free registered-state decodes.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, count 0, busy 0, done 0, dir 0, latched target/dwell 0, en 0.
REQ-028 rst asserted mid-sweep SHALL abandon the sweep; no done pulse is produced.
REQ-029 After rst deasserts, first start is accepted on the next edge.

Structure
REQ-030 State encodings and default WIDTH/DWELL_W SHALL live in shared package counter_defs.
REQ-031 Block SHALL instantiate the existing module counter (ports clk, rst, en, dn, count) as its single sub-module; no duplicate counting logic.
REQ-032 Control FSM, dwell counter and latches SHALL be in count_seq itself.

Verification
REQ-033 Reset, then start with target=5, dwell=2 -> count 0..5 up, held 3 cycles, 5..0 down; one done pulse; busy low after.
REQ-034 Leave count at 9 (abort), then start with target=4 -> dir=1; count 9->4 down, then ->0; done pulses once.
REQ-035 start with target=0 from count 0, dwell=0 -> SEEK 1 cycle, DWELL 1 cycle, RETURN 1 cycle, DONE; count stays 0.
REQ-036 abort during DWELL at count=7 -> IDLE next edge; count stays 7; no done; start re-accepted.
REQ-037 rst pulse during RETURN at count=3 -> count 0 asynchronously, IDLE, no done.
REQ-038 start pulses while busy, and start+abort together in IDLE -> no state or latch change.

Source files
------------

// File: rtl/counter_defs.sv
// Shared definitions for the sweep sequencer and its counter.
// Holds default widths and the sequencer state encoding.
package counter_defs;

  localparam int WIDTH_D   = 4;
  localparam int DWELL_W_D = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEEK   = 3'd1,
    S_DWELL  = 3'd2,
    S_RETURN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/counter.sv
// Up/down counter, one step per enabled edge.
// Ports: clk, rst (async high), en, dn (1=down), count.
module counter
  import counter_defs::*;
#(
  parameter int WIDTH = WIDTH_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= dn ? count - 1'b1
                  : count + 1'b1;
  end

endmodule

// File: rtl/count_seq.sv
// Sweep sequencer: 0/current -> target -> hold -> 0.
// Ports: clk, rst, start, abort, target, dwell, count, busy, done, dir.
module count_seq
  import counter_defs::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int DWELL_W = DWELL_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   target,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               dir
);

  state_t st, nx;

  logic [WIDTH-1:0]   tgt;
  logic [DWELL_W-1:0] dwl;
  logic [DWELL_W-1:0] dcnt;
  logic               dir_q;
  logic               busy_q;
  logic               done_q;
  logic               en;
  logic               dn;
  logic               at_tgt;
  logic               at_zero;

  assign at_tgt  = (count == tgt);
  assign at_zero = (count == '0);

  counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .dn    (dn),
    .count (count)
  );

  // abort blocks en so the count freezes on the abort edge
  always_comb begin
    nx = st;
    en = 1'b0;
    dn = dir_q;
    unique case (st)
      S_IDLE: begin
        if (start && !abort)
          nx = S_SEEK;
      end
      S_SEEK: begin
        if (abort)
          nx = S_IDLE;
        else if (at_tgt)
          nx = S_DWELL;
        else
          en = 1'b1;
      end
      S_DWELL: begin
        if (abort)
          nx = S_IDLE;
        else if (dcnt == '0)
          nx = S_RETURN;
      end
      S_RETURN: begin
        dn = 1'b1;
        if (abort)
          nx = S_IDLE;
        else if (at_zero)
          nx = S_DONE;
        else
          en = 1'b1;
      end
      S_DONE: begin
        nx = S_IDLE;
      end
      default: begin
        nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_IDLE;
      tgt    <= '0;
      dwl    <= '0;
      dcnt   <= '0;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= nx;
      busy_q <= (nx == S_SEEK) ||
                (nx == S_DWELL) ||
                (nx == S_RETURN);
      done_q <= (nx == S_DONE);
      if (st == S_IDLE && nx == S_SEEK) begin
        tgt   <= target;
        dwl   <= dwell;
        dir_q <= (count > target);
      end
      if (st == S_SEEK && nx == S_DWELL)
        dcnt <= dwl;
      else if (st == S_DWELL && dcnt != '0)
        dcnt <= dcnt - 1'b1;
      if (st == S_DWELL && nx == S_RETURN)
        dir_q <= 1'b1;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_count_seq.sv
// Self-checking bench for count_seq.
// Sweep model precomputes each sweep as a queue of snapshots.
module tb_count_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] target;
  logic [3:0] dwell;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       dir;

  count_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .target (target),
    .dwell  (dwell),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .dir    (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic       b;
    logic       d;
    logic       r;
  } snap_t;

  snap_t q[$];
  snap_t cur;
  int    checks = 0;
  int    errors = 0;
  int    npulse = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic snap_t mk(input int c, input logic b,
                               input logic d, input logic r);
    snap_t s;
    s.c = c[3:0];
    s.b = b;
    s.d = d;
    s.r = r;
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    cur = mk(0, 0, 0, 0);
  endtask

  // whole sweep: seek, hold dwell+1, return to zero, done
  task automatic plan(input int t, input int dw);
    int   c0;
    logic dd;
    int   v;
    c0 = cur.c;
    dd = (c0 > t);
    v  = c0;
    forever begin
      q.push_back(mk(v, 1, 0, dd));
      if (v == t) break;
      v = dd ? v - 1 : v + 1;
    end
    for (int i = 0; i <= dw; i++)
      q.push_back(mk(t, 1, 0, dd));
    for (int k = t; k >= 0; k--)
      q.push_back(mk(k, 1, 0, 1));
    q.push_back(mk(0, 0, 1, 1));
  endtask

  task automatic model_edge(input logic s, input logic a,
                            input int t, input int dw);
    if (cur.b && a) begin
      q.delete();
      cur.b = 0;
      cur.d = 0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur.d) begin
      cur.d = 0;
    end else if (s && !a) begin
      plan(t, dw);
      cur = q.pop_front();
    end
  endtask

  task automatic compare();
    chk("count", count, cur.c);
    chk("busy", busy, cur.b);
    chk("done", done, cur.d);
    chk("dir", dir, cur.r);
    if (done === 1'b1) npulse++;
  endtask

  task automatic step(input logic s, input logic a,
                      input int t, input int dw);
    start  = s;
    abort  = a;
    target = t[3:0];
    dwell  = dw[3:0];
    @(posedge clk);
    model_edge(s, a, t, dw);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // called just after a falling edge
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic run_to(input int val, input logic rq,
                        input int bound);
    int n;
    n = 0;
    while (!(cur.b && cur.c == val && cur.r == rq)) begin
      if (n >= bound) begin
        errors++;
        $display("FAIL run_to: count %0d never reached", val);
        return;
      end
      step(0, 0, 0, 0);
      n++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    dwell  = '0;
    model_reset();
    @(negedge clk);
    compare();
    chk("rst_count_lit", count, 0);
    rst = 1'b0;

    // latency example: target 3, dwell 1
    step(1, 0, 3, 1);
    idle(3);
    chk("ex_count3", count, 3);
    idle(7);
    chk("ex_done", done, 1);
    chk("ex_done_busy", busy, 0);
    idle(1);
    chk("ex_done_drop", done, 0);

    // target 5 dwell 2
    npulse = 0;
    step(1, 0, 5, 2);
    idle(25);
    chk("t5_pulses", npulse, 1);
    chk("t5_busy_after", busy, 0);

    // leave count at 9, then sweep down to 4
    step(1, 0, 9, 0);
    run_to(9, 0, 20);
    step(0, 1, 0, 0);
    chk("abort9_count", count, 9);
    chk("abort9_busy", busy, 0);
    npulse = 0;
    step(1, 0, 4, 0);
    chk("down_dir", dir, 1);
    idle(20);
    chk("down_pulses", npulse, 1);
    chk("down_end", count, 0);

    // zero target, zero dwell
    step(1, 0, 0, 0);
    idle(3);
    chk("zero_done", done, 1);
    chk("zero_count", count, 0);
    idle(1);

    // abort during dwell at 7
    npulse = 0;
    step(1, 0, 7, 5);
    idle(8);
    step(0, 1, 0, 0);
    chk("abort7_count", count, 7);
    chk("abort7_busy", busy, 0);
    idle(2);
    chk("abort7_pulses", npulse, 0);
    step(1, 0, 2, 0);
    chk("reaccept_busy", busy, 1);
    idle(20);

    // reset during return at 3
    npulse = 0;
    step(1, 0, 6, 0);
    run_to(3, 1, 30);
    rst_pulse();
    step(0, 0, 0, 0);
    chk("rst_mid_idle", busy, 0);
    idle(3);
    chk("rst_mid_pulses", npulse, 0);
    step(1, 0, 1, 0);
    chk("after_rst_start", busy, 1);
    idle(10);

    // ignored starts while busy; start+abort in idle
    step(1, 0, 4, 3);
    for (int i = 0; i < 6; i++)
      step(1, 0, 9, 9);
    idle(20);
    step(1, 1, 5, 5);
    chk("start_abort_idle", busy, 0);
    idle(2);

    // randomized
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst_pulse();
      end
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 15),
           $urandom_range(0, 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
